ifetch_mem_port: RTL
====================

// Module: ifetch_mem_port
// PURPOSE
//  Responder side of the instruction-fetch read interface. Accepts a single-cycle fetch request
//  carrying a 32-bit PC, reads 4 bytes from the 8-bit-wide synchronous RAM, and returns one
//  little-endian 32-bit instruction word with a one-cycle ok pulse. Sits between the fetch stage
//  and the RAM byte port; a redirect (flush or new request) aborts any in-flight read.
// PARAMETERS
//  ADDR_W    32  width of the fetch PC and of the RAM byte address
//  WORD_B    4   bytes per instruction word (fixed at 4; other values unsupported)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset         in   1       synchronous, active-high
//  ready         in   1       global enable; low = freeze all state and outputs
//  ifetch_req    in   1       one-cycle request pulse from fetch
//  ifetch_addr   in   ADDR_W  PC to fetch, valid with ifetch_req
//  flush         in   1       redirect/abort; kill in-flight read
//  ifetch_ok     out  1       one-cycle pulse: ifetch_data valid
//  ifetch_data   out  32      assembled word {b3,b2,b1,b0}, held until next ok
//  ram_rd_en     out  1       RAM read strobe for ram_addr this cycle
//  ram_addr      out  ADDR_W  RAM byte address
//  ram_din       in   8       RAM read data; byte for address presented in cycle t is valid in cycle t+1
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, base=0, ifetch_ok=0, ifetch_data=0, ram_rd_en=0, ram_addr=0.
//  ready=0: no register changes (ok pulse stretches if frozen mid-pulse; fetch also gated by ready).
//  States: IDLE, READ (cnt 0..3 = byte index being captured next).
//  Edge E0 (IDLE, ifetch_req=1): base<=ifetch_addr, ram_addr<=ifetch_addr, ram_rd_en<=1, cnt<=0, ->READ.
//  Edges E1..E3 (READ): byte[cnt]<=ram_din, ram_addr<=base+cnt+1, cnt<=cnt+1.
//  Edge E4 (READ, cnt=3): byte3<=ram_din, ifetch_data<={ram_din,b2,b1,b0}, ifetch_ok<=1, ram_rd_en<=0, ->IDLE.
//  Latency: ok high during cycle after E4 = 4 cycles after request sampled; next req accepted in IDLE.
//  ifetch_ok is 0 on every edge except E4; ifetch_data changes only at E4.
//  Address arithmetic: base+n mod 2^ADDR_W (wrap at top of space, no carry-out, no alignment check).
//  flush=1 (any state): abort, ifetch_ok<=0, ram_rd_en<=0, ->IDLE, partial bytes discarded,
//   ifetch_data keeps last completed word. flush and ifetch_req same edge: flush wins abort,
//   then request accepted exactly as E0 with the new address.
//  ifetch_req while READ (no flush): treated as redirect; restart at E0 with new address.
//  flush and E4 completion same edge: flush wins, no ok pulse, ifetch_data unchanged.
//  reset mid-READ: immediate return to reset values; no ok pulse.
//  ram_din ignored in IDLE and in the cycle after an abort.
// STRUCTURE
//  Shared package/def.v: PC_LEN/INS_LEN ranges, state encoding constants (ST_IDLE, ST_READ).
//  Single module; no sub-module needed (byte assembly is a 3x8-bit shift/index register).
// TESTING
//  1. req addr=0x100, RAM[0x100..0x103]=13 05 00 00 -> ram_addr 100,101,102,103 on consecutive
//     cycles; ok 1 cycle, data=0x00000513, 4 cycles after req.
//  2. Back-to-back: req 0x0, req 0x4 the cycle after ok -> two ok pulses, correct words, no
//     spurious ok, ram_rd_en low only in gap cycles.
//  3. req 0x200, flush at cnt=2 together with req 0x300 -> no ok for 0x200; ok with RAM[0x300..303]
//     word, ifetch_data holds prior word until then.
//  4. flush coincident with E4 -> no ok pulse; ifetch_data unchanged; state IDLE.
//  5. req 0xFFFFFFFE -> ram_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001; data assembled in that order.
//  6. ready=0 for 3 cycles mid-READ, then reset mid-READ on another request -> freeze resumes with
//     correct word; reset clears all outputs, no ok pulse.

Source files
------------

// File: rtl/ifetch_mem_port_pkg.sv
// Shared definitions for the instruction-fetch memory port.
// Covers word geometry and the fetch sequencer state encoding.
package ifetch_mem_port_pkg;

   localparam int INS_LEN = 32;
   localparam int WORD_B  = 4;
   localparam int BYTE_W  = 8;

   // Index of the byte whose capture completes a word.
   localparam logic [1:0] LAST_BYTE = 2'(WORD_B - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } fetchState_t;

endpackage

// File: rtl/ifetch_mem_port.sv
// Responder for instruction-fetch reads: gathers four RAM bytes into one
// little-endian word and flags it with a single-cycle ok pulse.
module ifetch_mem_port
   import ifetch_mem_port_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ready,
   input  logic                ifetch_req,
   input  logic [ADDR_W-1:0]   ifetch_addr,
   input  logic                flush,
   output logic                ifetch_ok,
   output logic [INS_LEN-1:0]  ifetch_data,
   output logic                ram_rd_en,
   output logic [ADDR_W-1:0]   ram_addr,
   input  logic [BYTE_W-1:0]   ram_din
);

   fetchState_t          r_state;
   logic [1:0]           r_cnt;
   logic [ADDR_W-1:0]    r_base;
   logic [BYTE_W-1:0]    r_b0;
   logic [BYTE_W-1:0]    r_b1;
   logic [BYTE_W-1:0]    r_b2;
   logic                 r_ok;
   logic [INS_LEN-1:0]   r_data;
   logic                 r_rdEn;
   logic [ADDR_W-1:0]    r_addr;

   logic [ADDR_W-1:0]    w_cntExt;
   logic [ADDR_W-1:0]    w_nextAddr;

   // Address of the byte after the one being captured; wraps modulo 2^ADDR_W.
   assign w_cntExt   = {{(ADDR_W-2){1'b0}}, r_cnt};
   assign w_nextAddr = r_base + w_cntExt + ADDR_W'(1);

   // A new request always restarts the sequence, so it outranks flush and any
   // in-flight read; flush alone just drops back to idle keeping the last word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 2'd0;
         r_base  <= '0;
         r_b0    <= '0;
         r_b1    <= '0;
         r_b2    <= '0;
         r_ok    <= 1'b0;
         r_data  <= '0;
         r_rdEn  <= 1'b0;
         r_addr  <= '0;
      end else if (ready) begin
         r_ok <= 1'b0;
         if (ifetch_req) begin
            r_base  <= ifetch_addr;
            r_addr  <= ifetch_addr;
            r_rdEn  <= 1'b1;
            r_cnt   <= 2'd0;
            r_state <= ST_READ;
         end else if (flush) begin
            r_rdEn  <= 1'b0;
            r_cnt   <= 2'd0;
            r_state <= ST_IDLE;
         end else if (r_state == ST_READ) begin
            if (r_cnt == LAST_BYTE) begin
               r_data  <= {ram_din, r_b2, r_b1, r_b0};
               r_ok    <= 1'b1;
               r_rdEn  <= 1'b0;
               r_cnt   <= 2'd0;
               r_state <= ST_IDLE;
            end else begin
               case (r_cnt)
                  2'd0:    r_b0 <= ram_din;
                  2'd1:    r_b1 <= ram_din;
                  default: r_b2 <= ram_din;
               endcase
               r_addr <= w_nextAddr;
               r_cnt  <= r_cnt + 2'd1;
            end
         end
      end
   end

   assign ifetch_ok   = r_ok;
   assign ifetch_data = r_data;
   assign ram_rd_en   = r_rdEn;
   assign ram_addr    = r_addr;

endmodule
